aes_inv_key_sched: RTL and testbench

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

---
 rtl/aes_inv_key_sched_pkg.sv | 16 +
 rtl/aes_sbox.sv | 38 +++
 rtl/aes_inv_key_sched.sv | 86 ++++++++
 tb/tb_aes_inv_key_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_key_sched_pkg.sv
// Shared types and constants for the inverse AES-128 key schedule.
package aes_inv_key_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Round constant used to derive the final (round-10) key.
  localparam logic [7:0] RCON_LAST     = 8'h36;
  // Inverse of xtime: (x>>1) ^ (x[0] ? 8'h8D : 0) walks rcon backwards.
  localparam logic [7:0] RCON_INV_POLY = 8'h8D;
  localparam logic [3:0] LAST_ROUND    = 4'd10;

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) multiplicative inverse followed by the affine map.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = '0;
    x = a;
    y = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inv = din^254 (product of din^(2^k), k=1..7); zero maps to zero.
  always_comb begin
    sq  = din;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_inv_key_sched.sv
// Inverse AES-128 key schedule: streams round keys 10 down to 0 from the final round key.
module aes_inv_key_sched
  import aes_inv_key_sched_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
  output logic         busy,
  output logic         rk_valid,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_round,
  output logic         done
);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  rcon;
  logic [7:0]  rcon_nxt;
  logic        hs;
  logic        load;
  logic        step;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] rot;
  logic [31:0] sub;

  assign busy     = (state != IDLE);
  assign rk_valid = (state == EMIT);
  assign done     = (state == DONE);

  assign hs   = rk_valid & rk_ready;
  assign load = (state == IDLE) & start;
  assign step = hs & (rk_round != '0);

  // Undo one forward expansion step; w0 needs the already-recovered w3.
  assign {w0, w1, w2, w3} = rk_out;
  assign n3  = w3 ^ w2;
  assign n2  = w2 ^ w1;
  assign n1  = w1 ^ w0;
  assign rot = {n3[23:0], n3[31:24]};
  assign n0  = w0 ^ sub ^ {rcon, 24'h0};

  assign rcon_nxt = {1'b0, rcon[7:1]} ^ (rcon[0] ? RCON_INV_POLY : 8'h00);

  aes_sbox u_sbox3 (.din(rot[31:24]), .dout(sub[31:24]));
  aes_sbox u_sbox2 (.din(rot[23:16]), .dout(sub[23:16]));
  aes_sbox u_sbox1 (.din(rot[15:8]),  .dout(sub[15:8]));
  aes_sbox u_sbox0 (.din(rot[7:0]),   .dout(sub[7:0]));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EMIT;
      EMIT:    if (hs && rk_round == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Round key, round index and rcon: load on accept, step on each non-final handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rk_out   <= '0;
      rk_round <= '0;
      rcon     <= '0;
    end else if (load) begin
      rk_out   <= key_in;
      rk_round <= LAST_ROUND;
      rcon     <= RCON_LAST;
    end else if (step) begin
      rk_out   <= {n0, n1, n2, n3};
      rk_round <= rk_round - 4'd1;
      rcon     <= rcon_nxt;
    end
  end

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched against a table-driven reference model.
module tb_aes_inv_key_sched;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [127:0] got [0:10];

  localparam logic [127:0] K_FINAL = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K_R9    = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] K_R0    = 128'h000102030405060708090a0b0c0d0e0f;

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // rcon used to step from round r to r-1, listed for r = 10 down to 1.
  logic [7:0] rcon_tab [10] = '{8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  aes_inv_key_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_in   (key_in),
    .rk_ready (rk_ready),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_out   (rk_out),
    .rk_round (rk_round),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    int idx;
    row = sbox_rows[b[7:4]];
    idx = (15 - int'(b[3:0])) * 8;
    return row[idx +: 8];
  endfunction

  // Reference: previous round key from key r and the rcon that produced it.
  function automatic logic [127:0] prev_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w [4];
    logic [31:0] p [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    p[3] = w[3] ^ w[2];
    p[2] = w[2] ^ w[1];
    p[1] = w[1] ^ w[0];
    t = {p[3][23:0], p[3][31:24]};
    t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])};
    p[0] = w[0] ^ t ^ {rc, 24'h0};
    return {p[0], p[1], p[2], p[3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a run with key k and follow it to the IDLE cycle after DONE.
  task automatic run_keys(input logic [127:0] k, input bit rand_ready,
                          input int start_round, input bit hold_start, input bit chk_rcon);
    logic [127:0] exp [0:10];
    int r;
    int cyc;
    bit acc;
    exp[10] = k;
    for (int i = 10; i > 0; i--) exp[i-1] = prev_key(exp[i], rcon_tab[10-i]);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    r   = 10;
    cyc = 0;
    while (r >= 0 && cyc < 300) begin
      start  = hold_start || (r == start_round);
      key_in = (r == start_round) ? {$urandom, $urandom, $urandom, $urandom} : k;
      chk("rk_valid", 128'(rk_valid), 128'(1));
      chk("busy", 128'(busy), 128'(1));
      chk("done_low", 128'(done), 128'(0));
      chk("rk_round", 128'(rk_round), 128'(r));
      chk("rk_out", rk_out, exp[r]);
      if (chk_rcon && r > 0) chk("rcon", 128'(dut.rcon), 128'(rcon_tab[10-r]));
      got[r]   = rk_out;
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      acc      = rk_ready;
      @(negedge clk);
      if (acc) r--;
      cyc++;
    end
    chk("run_complete", 128'(r + 1), 128'(0));
    rk_ready = 1'b0;
    if (!hold_start) start = 1'b0;
    chk("done_pulse", 128'(done), 128'(1));
    chk("valid_drop", 128'(rk_valid), 128'(0));
    @(negedge clk);
    chk("idle_done", 128'(done), 128'(0));
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_valid", 128'(rk_valid), 128'(0));
  endtask

  initial begin
    int cyc;
    logic [127:0] k;
    rst_n    = 1'b0;
    start    = 1'b0;
    rk_ready = 1'b0;
    key_in   = '0;
    #3;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_out", rk_out, '0);
    chk("rst_round", 128'(rk_round), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Known vector, ready held high.
    run_keys(K_FINAL, 1'b0, -1, 1'b0, 1'b1);
    chk("vec_r9", got[9], K_R9);
    chk("vec_r0", got[0], K_R0);

    // Same vector with back-pressure.
    run_keys(K_FINAL, 1'b1, -1, 1'b0, 1'b1);
    chk("stall_r9", got[9], K_R9);
    chk("stall_r0", got[0], K_R0);

    // Stray start during round 6 must be ignored.
    run_keys(K_FINAL, 1'b1, 6, 1'b0, 1'b0);
    chk("midstart_r0", got[0], K_R0);

    // Random keys with random back-pressure.
    for (int n = 0; n < 3; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      run_keys(k, 1'b1, -1, 1'b0, 1'b1);
    end

    // Asynchronous reset at round 4.
    @(negedge clk);
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    start    = 1'b0;
    rk_ready = 1'b1;
    cyc = 0;
    while (rk_round !== 4'd4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reach_r4", 128'(rk_round), 128'(4));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_valid", 128'(rk_valid), 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    chk("arst_out", rk_out, '0);
    chk("arst_round", 128'(rk_round), 128'(0));
    chk("arst_rcon", 128'(dut.rcon), 128'(0));
    rk_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_keys(K_FINAL, 1'b1, -1, 1'b0, 1'b1);
    chk("post_rst_r0", got[0], K_R0);

    // start held high: DONE, one IDLE cycle, then a fresh run.
    run_keys(K_FINAL, 1'b0, -1, 1'b1, 1'b0);
    @(negedge clk);
    chk("rerun_valid", 128'(rk_valid), 128'(1));
    chk("rerun_busy", 128'(busy), 128'(1));
    chk("rerun_round", 128'(rk_round), 128'(10));
    chk("rerun_key", rk_out, K_FINAL);
    start    = 1'b0;
    rk_ready = 1'b1;
    repeat (13) @(negedge clk);
    chk("final_idle", 128'(busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
